// File: rtl/l1_mem_dump.sv
// l1_mem_dump: streams the whole contents of a single-port SRAM out over a
// valid/ready port, in ascending address order.
// A 2-entry {addr, data} FIFO sits between the SRAM and the port. A read is
// issued only when it is guaranteed a FIFO slot, so the port outputs are
// driven from registers only.
module l1_mem_dump #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MEM_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             MEM_EN,
  output logic             MEM_WE,
  output logic [AW-1:0]    MEM_ADDR,
  input  logic [WIDTH-1:0] MEM_RDATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [AW-1:0]    OUT_ADDR,
  output logic [WIDTH-1:0] OUT_DATA
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_rd_addr;
  logic             r_inflight;
  logic [AW-1:0]    r_infl_addr;
  logic             r_done;

  // FIFO entry 0 is always the head; a dequeue shifts entry 1 down.
  logic [1:0]       r_count;
  logic [AW-1:0]    r_q_addr [2];
  logic [WIDTH-1:0] r_q_data [2];

  logic             w_valid;
  logic             w_deq;
  logic [1:0]       w_after_deq;
  logic [1:0]       w_occupancy;
  logic             w_issue;
  logic             w_last_hs;
  logic             w_wr_slot1;

  // Handshake, credit check and FIFO write-slot selection
  always_comb begin
    w_valid     = (r_count != 2'd0);
    w_deq       = w_valid && OUT_READY;
    w_after_deq = r_count - {1'b0, w_deq};
    w_occupancy = w_after_deq + {1'b0, r_inflight};
    w_issue     = !RST && (r_state == S_RUN) && (w_occupancy < 2'd2);
    w_last_hs   = w_deq && (r_q_addr[0] == LAST_ADDR);
    w_wr_slot1  = (w_after_deq == 2'd1);
  end

  // Output drive; everything forced to zero while reset is asserted
  always_comb begin
    BUSY      = !RST && (r_state != S_IDLE);
    DONE      = !RST && r_done;
    MEM_EN    = w_issue;
    MEM_WE    = 1'b0;
    MEM_ADDR  = w_issue ? r_rd_addr : '0;
    OUT_VALID = !RST && w_valid;
    OUT_ADDR  = (!RST && w_valid) ? r_q_addr[0] : '0;
    OUT_DATA  = (!RST && w_valid) ? r_q_data[0] : '0;
  end

  // Control FSM: read issue counter, in-flight tag and completion pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_rd_addr   <= '0;
      r_inflight  <= 1'b0;
      r_infl_addr <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_inflight  <= w_issue;
      r_infl_addr <= w_issue ? r_rd_addr : '0;
      case (r_state)
        S_IDLE: begin
          // a START coinciding with the DONE pulse does not restart
          if (START && MEM_READY && !r_done) begin
            r_state   <= S_RUN;
            r_rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (r_rd_addr == LAST_ADDR) begin
              r_state <= S_DRAIN;
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_last_hs) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO: enqueue returning read data, dequeue on handshake
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count     <= 2'd0;
      r_q_addr[0] <= '0;
      r_q_addr[1] <= '0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
    end else begin
      r_count <= w_after_deq + {1'b0, r_inflight};
      if (r_inflight && !w_wr_slot1) begin
        r_q_addr[0] <= r_infl_addr;
        r_q_data[0] <= MEM_RDATA;
      end else if (w_deq) begin
        r_q_addr[0] <= r_q_addr[1];
        r_q_data[0] <= r_q_data[1];
      end
      if (r_inflight && w_wr_slot1) begin
        r_q_addr[1] <= r_infl_addr;
        r_q_data[1] <= MEM_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_l1_mem_dump.sv
// Directed testbench for l1_mem_dump with DEPTH=8 and a registered SRAM
// model preloaded with word i = 0x100 + i.
module tb_l1_mem_dump;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        MEM_READY;
  logic        BUSY;
  logic        DONE;
  logic        MEM_EN;
  logic        MEM_WE;
  logic [2:0]  MEM_ADDR;
  logic [31:0] MEM_RDATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [2:0]  OUT_ADDR;
  logic [31:0] OUT_DATA;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [8];

  l1_mem_dump #(.WIDTH(32), .DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MEM_READY(MEM_READY),
    .BUSY(BUSY), .DONE(DONE), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_ADDR(OUT_ADDR), .OUT_DATA(OUT_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + 32'(i);
    MEM_RDATA = '0;
  end

  // registered single-port SRAM read
  always @(posedge CLK) begin
    if (MEM_EN) MEM_RDATA <= mem[MEM_ADDR];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; MEM_READY = 1'b1; OUT_READY = 1'b0;
    tick(); tick();
    n_vec++;
    if ({BUSY, DONE, MEM_EN, MEM_WE, OUT_VALID} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 00000", {BUSY, DONE, MEM_EN, MEM_WE, OUT_VALID});
    end
    n_vec++;
    if (MEM_ADDR !== 3'd0 || OUT_ADDR !== 3'd0 || OUT_DATA !== 32'd0) begin
      n_err++;
      $display("FAIL reset_buses: got maddr=%0d oaddr=%0d odata=%h expected 0/0/0", MEM_ADDR, OUT_ADDR, OUT_DATA);
    end
    RST = 1'b0;
    tick();
    n_vec++;
    if (BUSY !== 1'b0 || MEM_EN !== 1'b0 || OUT_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got busy=%b en=%b valid=%b expected 0/0/0", BUSY, MEM_EN, OUT_VALID);
    end
  endtask

  task automatic test_stream();
    logic        exp_en, exp_v, exp_done, exp_busy;
    logic [2:0]  exp_maddr, exp_oaddr;
    logic [31:0] exp_odata;
    OUT_READY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      exp_en    = (k <= 7);
      exp_maddr = exp_en ? 3'(k) : 3'd0;
      exp_v     = (k >= 2) && (k <= 9);
      exp_oaddr = exp_v ? 3'(k - 2) : 3'd0;
      exp_odata = exp_v ? 32'h100 + 32'(k - 2) : 32'd0;
      exp_done  = (k == 10);
      exp_busy  = (k < 10);
      n_vec++;
      if (MEM_EN !== exp_en || MEM_ADDR !== exp_maddr || MEM_WE !== 1'b0) begin
        n_err++;
        $display("FAIL stream_issue k=%0d: got en=%b addr=%0d we=%b expected en=%b addr=%0d we=0",
                 k, MEM_EN, MEM_ADDR, MEM_WE, exp_en, exp_maddr);
      end
      n_vec++;
      if (OUT_VALID !== exp_v || OUT_ADDR !== exp_oaddr || OUT_DATA !== exp_odata) begin
        n_err++;
        $display("FAIL stream_beat k=%0d: got v=%b a=%0d d=%h expected v=%b a=%0d d=%h",
                 k, OUT_VALID, OUT_ADDR, OUT_DATA, exp_v, exp_oaddr, exp_odata);
      end
      n_vec++;
      if (DONE !== exp_done || BUSY !== exp_busy) begin
        n_err++;
        $display("FAIL stream_status k=%0d: got done=%b busy=%b expected done=%b busy=%b",
                 k, DONE, BUSY, exp_done, exp_busy);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int          issued = 0;
    int          accepted = 0;
    bit          stalled = 0;
    bit          done_seen = 0;
    bit          deq;
    logic [2:0]  st_addr = '0;
    logic [31:0] st_data = '0;
    OUT_READY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int j = 0; j < 80 && !done_seen; j++) begin
      OUT_READY = ((j % 4) == 0) || ((j % 4) == 3);
      #1;
      deq = OUT_VALID && OUT_READY;
      if (stalled) begin
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT_ADDR !== st_addr || OUT_DATA !== st_data) begin
          n_err++;
          $display("FAIL bp_stable j=%0d: got v=%b a=%0d d=%h expected v=1 a=%0d d=%h",
                   j, OUT_VALID, OUT_ADDR, OUT_DATA, st_addr, st_data);
        end
      end
      if (MEM_EN === 1'b1) begin
        n_vec++;
        if ((issued - accepted - int'(deq)) >= 2 || MEM_ADDR !== 3'(issued)) begin
          n_err++;
          $display("FAIL bp_credit j=%0d: got addr=%0d outstanding=%0d expected addr=%0d outstanding<2",
                   j, MEM_ADDR, issued - accepted - int'(deq), issued);
        end
        issued++;
      end
      if (OUT_VALID === 1'b1) begin
        n_vec++;
        if (OUT_ADDR !== 3'(accepted) || OUT_DATA !== 32'h100 + 32'(accepted)) begin
          n_err++;
          $display("FAIL bp_order j=%0d: got a=%0d d=%h expected a=%0d d=%h",
                   j, OUT_ADDR, OUT_DATA, accepted, 32'h100 + 32'(accepted));
        end
      end
      if (deq) accepted++;
      stalled = OUT_VALID && !OUT_READY;
      st_addr = OUT_ADDR;
      st_data = OUT_DATA;
      if (DONE === 1'b1) begin
        done_seen = 1;
        n_vec++;
        if (BUSY !== 1'b0 || accepted != 8) begin
          n_err++;
          $display("FAIL bp_done: got busy=%b beats=%0d expected busy=0 beats=8", BUSY, accepted);
        end
      end
      tick();
    end
    n_vec++;
    if (!done_seen || issued != 8 || accepted != 8) begin
      n_err++;
      $display("FAIL bp_complete: got done=%0d issued=%0d beats=%0d expected 1/8/8", done_seen, issued, accepted);
    end
    OUT_READY = 1'b1;
  endtask

  task automatic test_init_gating();
    int en_seen = 0;
    int busy_seen = 0;
    MEM_READY = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 4; k++) begin
      en_seen   += int'(MEM_EN);
      busy_seen += int'(BUSY);
      tick();
    end
    n_vec++;
    if (en_seen != 0 || busy_seen != 0) begin
      n_err++;
      $display("FAIL init_gate: got en_cycles=%0d busy_cycles=%0d expected 0/0", en_seen, busy_seen);
    end
    MEM_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      en_seen   += int'(MEM_EN);
      busy_seen += int'(BUSY);
    end
    n_vec++;
    if (en_seen != 0 || busy_seen != 0) begin
      n_err++;
      $display("FAIL init_no_pending: got en_cycles=%0d busy_cycles=%0d expected 0/0", en_seen, busy_seen);
    end
  endtask

  task automatic test_mid_reset();
    bit done_seen = 0;
    OUT_READY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    // beat 3 handshook at the last edge
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    n_vec++;
    if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || MEM_EN !== 1'b0 || DONE !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_abort: got v=%b busy=%b en=%b done=%b expected 0/0/0/0", OUT_VALID, BUSY, MEM_EN, DONE);
    end
    tick();
    n_vec++;
    if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_discard: got v=%b busy=%b expected 0/0", OUT_VALID, BUSY);
    end
    START = 1'b1;
    tick();
    START = 1'b0;
    n_vec++;
    if (MEM_EN !== 1'b1 || MEM_ADDR !== 3'd0) begin
      n_err++;
      $display("FAIL midrst_replay_issue: got en=%b addr=%0d expected 1/0", MEM_EN, MEM_ADDR);
    end
    tick(); tick();
    n_vec++;
    if (OUT_VALID !== 1'b1 || OUT_ADDR !== 3'd0 || OUT_DATA !== 32'h100) begin
      n_err++;
      $display("FAIL midrst_replay_beat: got v=%b a=%0d d=%h expected 1/0/00000100", OUT_VALID, OUT_ADDR, OUT_DATA);
    end
    for (int k = 0; k < 20 && !done_seen; k++) begin
      tick();
      if (DONE === 1'b1) done_seen = 1;
    end
    n_vec++;
    if (!done_seen) begin
      n_err++;
      $display("FAIL midrst_finish: got no DONE within 20 cycles expected DONE");
    end
    tick();
  endtask

  task automatic test_ignored_start();
    int beats = 0;
    int dones = 0;
    OUT_READY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      if (OUT_VALID === 1'b1) begin
        n_vec++;
        if (OUT_ADDR !== 3'(beats) || OUT_DATA !== 32'h100 + 32'(beats)) begin
          n_err++;
          $display("FAIL ign_order k=%0d: got a=%0d d=%h expected a=%0d d=%h",
                   k, OUT_ADDR, OUT_DATA, beats, 32'h100 + 32'(beats));
        end
        beats++;
      end
      dones += int'(DONE);
      if (k == 11 || k == 12) begin
        n_vec++;
        if (BUSY !== 1'b0 || MEM_EN !== 1'b0) begin
          n_err++;
          $display("FAIL ign_restart k=%0d: got busy=%b en=%b expected 0/0", k, BUSY, MEM_EN);
        end
      end
      START = (k == 3) || (k == 10);
      tick();
    end
    START = 1'b0;
    n_vec++;
    if (beats != 8 || dones != 1) begin
      n_err++;
      $display("FAIL ign_count: got beats=%0d dones=%0d expected 8/1", beats, dones);
    end
  endtask

  task automatic test_last_word();
    OUT_READY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      OUT_READY = (k < 8) || (k >= 12);
      #1;
      if (k == 8) begin
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT_ADDR !== 3'd6) begin
          n_err++;
          $display("FAIL last_beat6: got v=%b a=%0d expected 1/6", OUT_VALID, OUT_ADDR);
        end
      end
      if (k >= 9 && k <= 12) begin
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT_ADDR !== 3'd6 || OUT_DATA !== 32'h106 || MEM_EN !== 1'b0 || BUSY !== 1'b1) begin
          n_err++;
          $display("FAIL last_hold k=%0d: got v=%b a=%0d d=%h en=%b busy=%b expected 1/6/00000106/0/1",
                   k, OUT_VALID, OUT_ADDR, OUT_DATA, MEM_EN, BUSY);
        end
      end
      if (k == 13) begin
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT_ADDR !== 3'd7 || OUT_DATA !== 32'h107 || DONE !== 1'b0) begin
          n_err++;
          $display("FAIL last_beat7: got v=%b a=%0d d=%h done=%b expected 1/7/00000107/0",
                   OUT_VALID, OUT_ADDR, OUT_DATA, DONE);
        end
      end
      if (k == 14) begin
        n_vec++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
          n_err++;
          $display("FAIL last_done: got done=%b busy=%b v=%b expected 1/0/0", DONE, BUSY, OUT_VALID);
        end
      end
      if (k == 15) begin
        n_vec++;
        if (DONE !== 1'b0) begin
          n_err++;
          $display("FAIL last_done_pulse: got done=%b expected 0", DONE);
        end
      end
      tick();
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; MEM_READY = 1'b1; OUT_READY = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_init_gating();
    test_mid_reset();
    test_ignored_start();
    test_last_word();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
